// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone slave-port arbiter.
// Arbiter FSM states, master-count limits and a one-hot to index encoder.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    localparam int MIN_MASTERS = 2;
    localparam int MAX_MASTERS = 8;
    localparam int MAX_IDX_W   = 3;

    // OR-reduction encoder: assumes at most one bit set, returns 0 for an all-zero input.
    function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_MASTERS-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin pick: the first requester at or after ptr wins, as a one-hot vector.
// Purely combinational, zero latency; no flow control of its own.
module wb_rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] gnt
);

    function automatic logic [IDX_W-1:0] slot(input logic [IDX_W-1:0] base, input int offs);
        int pos;
        pos = int'(base) + offs;
        if (pos >= NUM_MASTERS) begin
            pos = pos - NUM_MASTERS;
        end
        return IDX_W'(pos);
    endfunction

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt == '0 && req[slot(ptr, i)]) begin
                gnt[slot(ptr, i)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_slave_arbiter.sv
// Round-robin share of one Wishbone B4 classic slave port; grant held per bus cycle and LOCK.
// Grant one cycle after CYC, muxes combinational; stalls are bounded by a watchdog abort.
module wb_slave_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADR_W       = 64,
    parameter int DAT_W       = 64,
    parameter int TAG_W       = 16,
    parameter int TIMEOUT     = 256,
    localparam int SEL_W      = DAT_W / 8
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [NUM_MASTERS-1:0]       m_cyc_i,
    input  logic [NUM_MASTERS-1:0]       m_stb_i,
    input  logic [NUM_MASTERS-1:0]       m_we_i,
    input  logic [NUM_MASTERS-1:0]       m_lock_i,
    input  logic [NUM_MASTERS*ADR_W-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DAT_W-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SEL_W-1:0] m_sel_i,
    input  logic [NUM_MASTERS*TAG_W-1:0] m_tga_i,
    input  logic [NUM_MASTERS*TAG_W-1:0] m_tgc_i,
    input  logic [NUM_MASTERS*TAG_W-1:0] m_tgd_i,
    output logic [NUM_MASTERS-1:0]       m_ack_o,
    output logic [NUM_MASTERS-1:0]       m_err_o,
    output logic [NUM_MASTERS-1:0]       m_rty_o,
    output logic [DAT_W-1:0]             m_dat_o,
    output logic [TAG_W-1:0]             m_tgd_o,

    output logic                         s_cyc_o,
    output logic                         s_stb_o,
    output logic                         s_we_o,
    output logic                         s_lock_o,
    output logic [ADR_W-1:0]             s_adr_o,
    output logic [DAT_W-1:0]             s_dat_o,
    output logic [SEL_W-1:0]             s_sel_o,
    output logic [TAG_W-1:0]             s_tga_o,
    output logic [TAG_W-1:0]             s_tgc_o,
    output logic [TAG_W-1:0]             s_tgd_o,
    input  logic                         s_ack_i,
    input  logic                         s_err_i,
    input  logic                         s_rty_i,
    input  logic [DAT_W-1:0]             s_dat_i,
    input  logic [TAG_W-1:0]             s_tgd_i,

    output logic [NUM_MASTERS-1:0]       grant_o,
    output logic                         timeout_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int WDG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDG_W-1:0] WDG_LAST = WDG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit WDG_EN = (TIMEOUT > 0);

    if (NUM_MASTERS < MIN_MASTERS || NUM_MASTERS > MAX_MASTERS) begin : g_bad_cfg
        $error("wb_slave_arbiter: NUM_MASTERS out of range");
    end

    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic             lock;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
        logic [TAG_W-1:0] tga;
        logic [TAG_W-1:0] tgc;
        logic [TAG_W-1:0] tgd;
    } req_t;

    req_t                   req [NUM_MASTERS];
    req_t                   cur;
    arb_state_e             state;
    logic [NUM_MASTERS-1:0] grant;
    logic [NUM_MASTERS-1:0] pick;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       ptr_nxt;
    logic [IDX_W-1:0]       gidx;
    logic [IDX_W-1:0]       pick_idx;
    logic [WDG_W-1:0]       wdg_cnt;
    logic                   busy;
    logic                   abort;
    logic                   release_ok;
    logic                   ack_v;
    logic                   err_v;
    logic                   rty_v;
    logic                   term;
    logic                   wdg_fire;

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
        assign req[k] = '{
            cyc:  m_cyc_i[k],
            stb:  m_stb_i[k],
            we:   m_we_i[k],
            lock: m_lock_i[k],
            adr:  m_adr_i[k*ADR_W +: ADR_W],
            dat:  m_dat_i[k*DAT_W +: DAT_W],
            sel:  m_sel_i[k*SEL_W +: SEL_W],
            tga:  m_tga_i[k*TAG_W +: TAG_W],
            tgc:  m_tgc_i[k*TAG_W +: TAG_W],
            tgd:  m_tgd_i[k*TAG_W +: TAG_W]
        };
    end

    wb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req (m_cyc_i),
        .ptr (ptr),
        .gnt (pick)
    );

    assign gidx     = IDX_W'(onehot2idx(MAX_MASTERS'(grant)));
    assign pick_idx = IDX_W'(onehot2idx(MAX_MASTERS'(pick)));
    assign ptr_nxt  = (pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
    assign cur      = req[gidx];

    assign busy       = (state == BUSY);
    assign abort      = (state == ABORT);
    assign release_ok = ~cur.cyc & ~cur.lock;
    assign grant_o    = grant;

    // Everything slave-facing is forced low outside BUSY, which also covers ABORT, DRAIN and reset.
    assign s_cyc_o  = busy & cur.cyc;
    assign s_stb_o  = busy & cur.stb;
    assign s_we_o   = busy & cur.we;
    assign s_lock_o = busy & cur.lock;
    assign s_adr_o  = busy ? cur.adr : '0;
    assign s_dat_o  = busy ? cur.dat : '0;
    assign s_sel_o  = busy ? cur.sel : '0;
    assign s_tga_o  = busy ? cur.tga : '0;
    assign s_tgc_o  = busy ? cur.tgc : '0;
    assign s_tgd_o  = busy ? cur.tgd : '0;

    assign ack_v = s_cyc_o & s_ack_i;
    assign err_v = s_cyc_o & s_err_i;
    assign rty_v = s_cyc_o & s_rty_i;
    assign term  = ack_v | err_v | rty_v;

    assign m_ack_o = grant & {NUM_MASTERS{ack_v}};
    assign m_err_o = grant & {NUM_MASTERS{err_v | abort}};
    assign m_rty_o = grant & {NUM_MASTERS{rty_v}};
    assign m_dat_o = busy ? s_dat_i : '0;
    assign m_tgd_o = busy ? s_tgd_i : '0;

    // A termination in the expiry cycle clears term-gated fire, so the transfer completes normally.
    assign wdg_fire = WDG_EN && busy && s_stb_o && !term && (wdg_cnt == WDG_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= '0;
            ptr       <= '0;
            wdg_cnt   <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    wdg_cnt <= '0;
                    if (|m_cyc_i) begin
                        state <= BUSY;
                        grant <= pick;
                        ptr   <= ptr_nxt;
                    end
                end
                BUSY: begin
                    if (wdg_fire) begin
                        state     <= ABORT;
                        timeout_o <= 1'b1;
                        wdg_cnt   <= '0;
                    end else begin
                        wdg_cnt <= (s_stb_o && !term) ? wdg_cnt + 1'b1 : '0;
                        if (release_ok) begin
                            state <= IDLE;
                            grant <= '0;
                        end
                    end
                end
                ABORT: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (release_ok) begin
                        state <= IDLE;
                        grant <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_arbiter.sv
// Directed bench for wb_slave_arbiter with an in-order scoreboard of expected slave-side transfers.
module tb_wb_slave_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int TW = 16;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i, m_lock_i;
    logic [N*AW-1:0] m_adr_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N*SW-1:0] m_sel_i;
    logic [N*TW-1:0] m_tga_i, m_tgc_i, m_tgd_i;
    logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
    logic [DW-1:0]   m_dat_o;
    logic [TW-1:0]   m_tgd_o;
    logic            s_cyc_o, s_stb_o, s_we_o, s_lock_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [TW-1:0]   s_tga_o, s_tgc_o, s_tgd_o;
    logic            s_ack_i, s_err_i, s_rty_i;
    logic [DW-1:0]   s_dat_i;
    logic [TW-1:0]   s_tgd_i;
    logic [N-1:0]    grant_o;
    logic            timeout_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0]  gnt;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t sbq[$];

    wb_slave_arbiter #(
        .NUM_MASTERS (N),
        .ADR_W       (AW),
        .DAT_W       (DW),
        .TAG_W       (TW),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_lock_i  (m_lock_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_sel_i   (m_sel_i),
        .m_tga_i   (m_tga_i),
        .m_tgc_i   (m_tgc_i),
        .m_tgd_i   (m_tgd_i),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_rty_o   (m_rty_o),
        .m_dat_o   (m_dat_o),
        .m_tgd_o   (m_tgd_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_lock_o  (s_lock_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_tga_o   (s_tga_o),
        .s_tgc_o   (s_tgc_o),
        .s_tgd_o   (s_tgd_o),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .s_rty_i   (s_rty_i),
        .s_dat_i   (s_dat_i),
        .s_tgd_i   (s_tgd_i),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int k, input logic [AW-1:0] adr);
        exp_t e;
        e.gnt = N'(1) << k;
        e.adr = adr;
        e.dat = ~adr;
        sbq.push_back(e);
    endtask

    task automatic request(input int k, input logic [AW-1:0] adr);
        m_cyc_i[k]            = 1'b1;
        m_stb_i[k]            = 1'b1;
        m_we_i[k]             = 1'b1;
        m_adr_i[k*AW +: AW]   = adr;
        m_dat_i[k*DW +: DW]   = ~adr;
        m_sel_i[k*SW +: SW]   = '1;
        m_tga_i[k*TW +: TW]   = TW'(k);
    endtask

    task automatic release_m(input int k, input bit keep_lock);
        m_cyc_i[k] = 1'b0;
        m_stb_i[k] = 1'b0;
        if (!keep_lock) m_lock_i[k] = 1'b0;
    endtask

    task automatic wait_stb();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 32 && !seen; i++) begin
            @(negedge clk);
            if (s_stb_o) seen = 1'b1;
        end
        check("wait_stb", 64'(seen), 64'd1);
    endtask

    task automatic pop_check(output logic [N-1:0] g);
        exp_t e;
        g = '0;
        check("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            g = e.gnt;
            check("grant", 64'(grant_o), 64'(e.gnt));
            check("s_cyc", 64'(s_cyc_o), 64'd1);
            check("s_adr", s_adr_o, e.adr);
            check("s_dat", s_dat_o, e.dat);
        end
    endtask

    task automatic ack_and_release(input int k, input logic [N-1:0] g, input bit keep_lock);
        s_ack_i = 1'b1;
        s_dat_i = 64'hACE0_0000 + 64'(k);
        #1;
        check("ack_route", 64'(m_ack_o), 64'(g));
        check("rd_data", m_dat_o, 64'hACE0_0000 + 64'(k));
        check("no_err", 64'(m_err_o), 64'd0);
        @(posedge clk);
        #1;
        s_ack_i = 1'b0;
        release_m(k, keep_lock);
    endtask

    task automatic idle_check();
        @(posedge clk);
        @(negedge clk);
        check("idle_gnt", 64'(grant_o), 64'd0);
        check("idle_cyc", 64'(s_cyc_o), 64'd0);
    endtask

    initial begin
        logic [N-1:0] g;

        rst      = 1'b0;
        m_cyc_i  = '0; m_stb_i = '0; m_we_i = '0; m_lock_i = '0;
        m_adr_i  = '0; m_dat_i = '0; m_sel_i = '0;
        m_tga_i  = '0; m_tgc_i = '0; m_tgd_i = '0;
        s_ack_i  = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
        s_dat_i  = '0; s_tgd_i = '0;

        // Reset state
        @(negedge clk);
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_scyc", 64'(s_cyc_o), 64'd0);
        check("rst_tmo", 64'(timeout_o), 64'd0);
        check("rst_sadr", s_adr_o, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // All four masters request together: rotation 0,1,2,3 then 0 again
        for (int k = 0; k < N; k++) begin
            request(k, 64'h2000 + 64'(k * 16));
            push_exp(k, 64'h2000 + 64'(k * 16));
        end
        @(negedge clk);
        check("gnt_latency", 64'(grant_o), 64'd0);
        for (int n = 0; n < 5; n++) begin
            wait_stb();
            pop_check(g);
            ack_and_release(n % N, g, 1'b0);
            idle_check();
            if (n == 0) begin
                request(0, 64'h2040);
                push_exp(0, 64'h2040);
            end
        end

        // Single write from master 2
        request(2, 64'h1000);
        push_exp(2, 64'h1000);
        wait_stb();
        pop_check(g);
        check("m2_we", 64'(s_we_o), 64'd1);
        check("m2_sel", 64'(s_sel_o), 64'hFF);
        check("m2_tga", 64'(s_tga_o), 64'd2);
        ack_and_release(2, g, 1'b0);
        idle_check();

        // Master 1 locked across a 3-cycle CYC gap while master 0 waits
        m_lock_i[1] = 1'b1;
        request(1, 64'h3000);
        push_exp(1, 64'h3000);
        wait_stb();
        pop_check(g);
        request(0, 64'h3100);
        ack_and_release(1, g, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lock_gnt", 64'(grant_o), 64'b0010);
            check("lock_gap_cyc", 64'(s_cyc_o), 64'd0);
        end
        @(posedge clk);
        #1;
        request(1, 64'h3008);
        push_exp(1, 64'h3008);
        wait_stb();
        pop_check(g);
        ack_and_release(1, g, 1'b0);
        push_exp(0, 64'h3100);
        idle_check();
        wait_stb();
        pop_check(g);
        ack_and_release(0, g, 1'b0);
        idle_check();

        // Watchdog expiry with a silent slave, then DRAIN until the master lets go
        request(3, 64'h4000);
        push_exp(3, 64'h4000);
        wait_stb();
        pop_check(g);
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            check("wdg_quiet_tmo", 64'(timeout_o), 64'd0);
            check("wdg_quiet_err", 64'(m_err_o), 64'd0);
            check("wdg_quiet_cyc", 64'(s_cyc_o), 64'd1);
        end
        @(negedge clk);
        check("abort_tmo", 64'(timeout_o), 64'd1);
        check("abort_err", 64'(m_err_o), 64'b1000);
        check("abort_cyc", 64'(s_cyc_o), 64'd0);
        check("abort_stb", 64'(s_stb_o), 64'd0);
        @(negedge clk);
        check("drain_tmo", 64'(timeout_o), 64'd0);
        check("drain_err", 64'(m_err_o), 64'd0);
        check("drain_gnt", 64'(grant_o), 64'b1000);
        s_ack_i = 1'b1;
        #1;
        check("drain_ack_drop", 64'(m_ack_o), 64'd0);
        check("drain_cyc", 64'(s_cyc_o), 64'd0);
        @(posedge clk);
        #1 s_ack_i = 1'b0;
        @(negedge clk);
        check("drain_hold", 64'(grant_o), 64'b1000);
        release_m(3, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("drain_exit", 64'(grant_o), 64'd0);

        // Ack lands in the expiry cycle: normal completion, no abort
        request(2, 64'h5000);
        push_exp(2, 64'h5000);
        wait_stb();
        pop_check(g);
        repeat (TO - 1) @(negedge clk);
        s_ack_i = 1'b1;
        s_dat_i = 64'h5A5A;
        #1;
        check("race_ack", 64'(m_ack_o), 64'b0100);
        check("race_err", 64'(m_err_o), 64'd0);
        @(posedge clk);
        #1;
        s_ack_i = 1'b0;
        release_m(2, 1'b0);
        @(negedge clk);
        check("race_tmo", 64'(timeout_o), 64'd0);
        check("race_err2", 64'(m_err_o), 64'd0);
        check("race_gnt", 64'(grant_o), 64'b0100);
        idle_check();

        // Reset mid-transfer, then the pointer restarts at master 0
        request(1, 64'h6000);
        push_exp(1, 64'h6000);
        wait_stb();
        pop_check(g);
        #2 rst = 1'b0;
        #1;
        check("arst_gnt", 64'(grant_o), 64'd0);
        check("arst_cyc", 64'(s_cyc_o), 64'd0);
        check("arst_stb", 64'(s_stb_o), 64'd0);
        check("arst_adr", s_adr_o, 64'd0);
        check("arst_tmo", 64'(timeout_o), 64'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        request(0, 64'h6200);
        request(2, 64'h6300);
        request(3, 64'h6400);
        push_exp(0, 64'h6200);
        wait_stb();
        pop_check(g);
        ack_and_release(0, g, 1'b0);
        release_m(1, 1'b0);
        release_m(2, 1'b0);
        release_m(3, 1'b0);
        idle_check();

        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_slave_arbiter.md
# wb_slave_arbiter

Shares one Wishbone B4 classic slave port between `NUM_MASTERS` requesting masters. It sits in front of the testbench slave interface and the DUT slave path. Arbitration is round-robin and holds the grant for a whole bus cycle, and for locked sequences. A watchdog terminates stalled transfers with an error.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of requesters, 2..8.
- `ADR_W`, 64: address width.
- `DAT_W`, 64: data width. `SEL_W = DAT_W/8`.
- `TAG_W`, 16: width of TGA/TGC/TGD.
- `TIMEOUT`, 256: maximum cycles a strobe may wait for a termination. 0 disables the watchdog.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `m_cyc_i`, `m_stb_i`, `m_we_i`, `m_lock_i` in `NUM_MASTERS`: per-master control, one bit per master.
- `m_adr_i` in `NUM_MASTERS*ADR_W`: packed addresses; master k uses slice k.
- `m_dat_i` in `NUM_MASTERS*DAT_W`: packed write data.
- `m_sel_i` in `NUM_MASTERS*SEL_W`: packed byte selects.
- `m_tga_i`, `m_tgc_i`, `m_tgd_i` in `NUM_MASTERS*TAG_W`: packed tags.
- `m_ack_o`, `m_err_o`, `m_rty_o` out `NUM_MASTERS`: terminations, routed to the granted master only.
- `m_dat_o` out `DAT_W`, `m_tgd_o` out `TAG_W`: read data and tag, broadcast to all masters.
- `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_lock_o` out 1: slave-side control.
- `s_adr_o` out `ADR_W`, `s_dat_o` out `DAT_W`, `s_sel_o` out `SEL_W`: slave-side address, data, selects.
- `s_tga_o`, `s_tgc_o`, `s_tgd_o` out `TAG_W`: slave-side tags.
- `s_ack_i`, `s_err_i`, `s_rty_i` in 1, `s_dat_i` in `DAT_W`, `s_tgd_i` in `TAG_W`: slave responses.
- `grant_o` out `NUM_MASTERS`: one-hot current owner; all zeros when idle.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires.

## Operation
States:
- IDLE: no owner.
  - Any `m_cyc_i` high → BUSY. The round-robin winner is registered into `grant_o`.
  - Search starts at (last granted + 1) mod `NUM_MASTERS`. After reset the pointer is 0, so master 0 has top priority.
- BUSY: slave signals are a mux of the granted master's inputs.
  - `s_cyc_o = m_cyc_i[g]`, `s_stb_o = m_stb_i[g]`.
  - Slave terminations go to `m_*_o[g]`; every other master sees ack/err/rty = 0.
  - Granted `m_cyc_i` low and `m_lock_i` low → IDLE.
  - `m_lock_i` high keeps the grant across CYC gaps. Slave `s_cyc_o` follows the master's CYC during such a gap.
- ABORT: entered from BUSY when the watchdog expires.
  - `m_err_o[g]` = 1 for exactly that one cycle; `timeout_o` = 1.
  - `s_cyc_o` and `s_stb_o` = 0.
  - Next state is DRAIN.
- DRAIN: `s_cyc_o` and `s_stb_o` held at 0.
  - Waits until the granted master drops both CYC and LOCK, then → IDLE.
  - Slave responses in this state are discarded.

Watchdog:
- Counts cycles in BUSY with `s_stb_o` = 1 and no ack/err/rty.
- Clears on any termination or when the strobe goes low.
- Fires when the count reaches `TIMEOUT`.
- A termination arriving in the same cycle as expiry wins, and no abort occurs.

Other rules:
- Slave termination signals that arrive while `s_cyc_o` = 0 are ignored.
- Reset is asynchronous and may be asserted mid-transfer. It forces IDLE immediately; all outputs go to 0, including `grant_o`, `timeout_o` and every `s_*_o`.

## Timing
- Grant latency: `m_cyc_i` high at edge n → `grant_o` and `s_cyc_o` high after edge n+1.
- Response path: data and terminations pass slave → master combinationally, with zero added latency.
- Request path: after the grant, the request mux is combinational. Pipelined throughput is unchanged.
- Handover: minimum one IDLE cycle with `s_cyc_o` = 0 between different owners.
- Simultaneous requests resolve in the same edge, by the pointer only.
- A master that drops CYC before being granted loses its request and causes no slave activity.
- Watchdog: strobe high from cycle t with no termination → ABORT in cycle t+`TIMEOUT`.

## Structure
- Package `wb_arb_pkg`:
  - state enum `arb_state_e` {IDLE, BUSY, ABORT, DRAIN};
  - `localparam` for the `NUM_MASTERS` limit;
  - one-hot to index function `onehot2idx`.
- Sub-module `wb_rr_picker`: combinational round-robin selection. Inputs are the request vector and the pointer; output is a one-hot winner.
- Top level holds the FSM, grant register, pointer, watchdog counter and muxes.

## Test plan
- Reset, then master 2 issues a single write to 0x1000: `grant_o` = 4'b0100 one cycle after CYC; slave sees ADR 0x1000; ack reaches only `m_ack_o[2]`.
- Masters 0..3 all request continuously with one transfer each: grants in order 0, 1, 2, 3, 0, with one idle cycle between owners.
- Master 1 holds LOCK across two cycles separated by a 3-cycle CYC gap, while master 0 requests: master 0 is granted only after master 1 drops LOCK.
- `TIMEOUT` = 8 and the slave never acks: exactly 8 cycles after STB, `m_err_o[g]` and `timeout_o` pulse once and `s_cyc_o` drops; DRAIN holds until the master releases CYC.
- Ack in the same cycle as watchdog expiry: normal ack only, no error, no `timeout_o`.
- `rst` asserted in the middle of a burst: all outputs go to 0 asynchronously; after release master 0 has priority.
